led_chaser_pwm: RTL and testbench



---
 rtl/led_chaser_pwm.sv | 139 +++++++++++++
 tb/tb_led_chaser_pwm.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_chaser_pwm.sv
// rtl/led_chaser_pwm.sv - multi-channel LED chase animator with PWM cross-fade
//
// A prescaled fractional position sweeps a "head" across N_CH channels. The
// channel under the head is fully lit and its neighbours cross-fade with the
// fractional part of the position.
//
// Ports:
//   clk    - system clock
//   rst    - synchronous active-high reset
//   hold   - 1 freezes position and prescaler; PWM keeps running
//   mode   - 0 bounce, 1 wrap, 2 single-dot bounce, 3 off
//   led    - registered PWM outputs, bit i = channel i
//   seg_o  - current head channel index
//   dir_o  - 0 ascending, 1 descending
//   tick_o - one-cycle pulse after each position step
module led_chaser_pwm #(
  parameter int N_CH   = 8,
  parameter int PWM_W  = 10,
  parameter int FRAC_W = 10,
  parameter int DIV    = 16384,
  localparam int SEG_W = (N_CH > 2) ? $clog2(N_CH) : 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             hold,
  input  logic [1:0]       mode,
  output logic [N_CH-1:0]  led,
  output logic [SEG_W-1:0] seg_o,
  output logic             dir_o,
  output logic             tick_o
);

  localparam int POS_W = SEG_W + FRAC_W;
  localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(DIV - 1);
  localparam logic [POS_W-1:0] POS_MAX  = POS_W'(N_CH * (2 ** FRAC_W) - 1);
  localparam logic [PWM_W-1:0] BMAX     = '1;

  localparam logic [1:0] M_WRAP   = 2'd1;
  localparam logic [1:0] M_SINGLE = 2'd2;
  localparam logic [1:0] M_OFF    = 2'd3;

  logic [PRE_W-1:0] pre;
  logic [POS_W-1:0] pos;
  logic             dir;
  logic [PWM_W-1:0] pwm_ctr;
  logic [PWM_W-1:0] bright     [N_CH];
  logic [PWM_W-1:0] bright_nxt [N_CH];
  logic             step;
  logic [SEG_W-1:0] seg;
  logic [PWM_W-1:0] f;

  // A held terminal count does not step; the prescaler simply waits at DIV-1.
  assign step  = (pre == PRE_LAST) && !hold;
  assign seg   = pos[POS_W-1 -: SEG_W];
  assign f     = pos[FRAC_W-1 -: PWM_W];
  assign seg_o = seg;
  assign dir_o = dir;

  always_ff @(posedge clk) begin
    if (rst) begin
      pre    <= '0;
      tick_o <= 1'b0;
    end else begin
      tick_o <= step;
      if (!hold) begin
        pre <= step ? '0 : pre + 1'b1;
      end
    end
  end

  // Wrap mode clears dir on every cycle so a later switch back to bounce
  // always resumes ascending.
  always_ff @(posedge clk) begin
    if (rst) begin
      pos <= '0;
      dir <= 1'b0;
    end else if (mode == M_WRAP) begin
      dir <= 1'b0;
      if (step) begin
        pos <= (pos == POS_MAX) ? '0 : pos + 1'b1;
      end
    end else if (step) begin
      if (!dir) begin
        if (pos == POS_MAX) begin
          dir <= 1'b1;
          pos <= POS_MAX - 1'b1;
        end else begin
          pos <= pos + 1'b1;
        end
      end else begin
        if (pos == '0) begin
          dir <= 1'b0;
          pos <= POS_W'(1);
        end else begin
          pos <= pos - 1'b1;
        end
      end
    end
  end

  // Head channel full, channel above fades in with f, channel below fades out.
  // Wrap mode closes the ring so channels 0 and N_CH-1 are neighbours.
  always_comb begin
    for (int i = 0; i < N_CH; i++) begin
      bright_nxt[i] = '0;
      if (mode == M_OFF) begin
        bright_nxt[i] = '0;
      end else if (int'(seg) == i) begin
        bright_nxt[i] = BMAX;
      end else if (mode == M_SINGLE) begin
        bright_nxt[i] = '0;
      end else if ((int'(seg) == i - 1) ||
                   (mode == M_WRAP && i == 0 && int'(seg) == N_CH - 1)) begin
        bright_nxt[i] = f;
      end else if ((int'(seg) == i + 1) ||
                   (mode == M_WRAP && i == N_CH - 1 && int'(seg) == 0)) begin
        bright_nxt[i] = BMAX - f;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pwm_ctr <= '0;
      led     <= '0;
      for (int i = 0; i < N_CH; i++) begin
        bright[i] <= '0;
      end
    end else begin
      pwm_ctr <= pwm_ctr + 1'b1;
      for (int i = 0; i < N_CH; i++) begin
        bright[i] <= bright_nxt[i];
        led[i]    <= (pwm_ctr < bright[i]);
      end
    end
  end

endmodule

// File: tb/tb_led_chaser_pwm.sv
// tb/tb_led_chaser_pwm.sv - self-checking bench for led_chaser_pwm
//
// Two instances share the inputs: dut1 steps every cycle (DIV=1), dut4 every
// fourth cycle (DIV=4). Both use N_CH=4, PWM_W=2, FRAC_W=2.
module tb_led_chaser_pwm;

  localparam int NCH     = 4;
  localparam int PWM_W   = 2;
  localparam int FRAC_W  = 2;
  localparam int FR      = 1 << FRAC_W;
  localparam int BMAX    = (1 << PWM_W) - 1;
  localparam int POS_MAX = NCH * FR - 1;

  logic           clk  = 1'b0;
  logic           rst  = 1'b1;
  logic           hold = 1'b0;
  logic [1:0]     mode = 2'd0;
  logic [NCH-1:0] led1, led4;
  logic [1:0]     seg1, seg4;
  logic           dir1, dir4, tick1, tick4;

  int n_vec = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  always #5 clk = ~clk;

  led_chaser_pwm #(.N_CH(NCH), .PWM_W(PWM_W), .FRAC_W(FRAC_W), .DIV(1)) dut1 (
    .clk(clk), .rst(rst), .hold(hold), .mode(mode),
    .led(led1), .seg_o(seg1), .dir_o(dir1), .tick_o(tick1)
  );

  led_chaser_pwm #(.N_CH(NCH), .PWM_W(PWM_W), .FRAC_W(FRAC_W), .DIV(4)) dut4 (
    .clk(clk), .rst(rst), .hold(hold), .mode(mode),
    .led(led4), .seg_o(seg4), .dir_o(dir4), .tick_o(tick4)
  );

  // Behavioural model: integer position, brightness from the channel rules.
  int div_of [2] = '{1, 4};
  int m_pre  [2];
  int m_pos  [2];
  int m_dir  [2];
  int m_tick [2];
  int m_br   [2][NCH];
  int m_led  [2][NCH];
  int m_pwm;

  function automatic int exp_bright(int pos, int md, int ch);
    int seg;
    int f;
    seg = pos / FR;
    f   = (pos % FR) >> (FRAC_W - PWM_W);
    if (md == 3) return 0;
    if (seg == ch) return BMAX;
    if (md == 2) return 0;
    if (seg == ch - 1 || (md == 1 && ch == 0 && seg == NCH - 1)) return f;
    if (seg == ch + 1 || (md == 1 && ch == NCH - 1 && seg == 0)) return BMAX - f;
    return 0;
  endfunction

  function automatic logic [31:0] mled(int k);
    logic [31:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) v[c] = (m_led[k][c] != 0);
    return v;
  endfunction

  task automatic model_clk();
    bit step;
    for (int k = 0; k < 2; k++) begin
      for (int c = 0; c < NCH; c++) m_led[k][c] = (m_pwm < m_br[k][c]) ? 1 : 0;
      for (int c = 0; c < NCH; c++) m_br[k][c] = exp_bright(m_pos[k], int'(mode), c);
      if (rst) begin
        m_pre[k] = 0; m_pos[k] = 0; m_dir[k] = 0; m_tick[k] = 0;
        for (int c = 0; c < NCH; c++) begin
          m_br[k][c] = 0;
          m_led[k][c] = 0;
        end
      end else begin
        step = (m_pre[k] == div_of[k] - 1) && !hold;
        m_tick[k] = step;
        if (!hold) m_pre[k] = step ? 0 : m_pre[k] + 1;
        if (mode == 2'd1) begin
          m_dir[k] = 0;
          if (step) m_pos[k] = (m_pos[k] + 1) % (POS_MAX + 1);
        end else if (step) begin
          if (m_dir[k] == 0) begin
            if (m_pos[k] == POS_MAX) begin m_dir[k] = 1; m_pos[k] = POS_MAX - 1; end
            else m_pos[k] = m_pos[k] + 1;
          end else begin
            if (m_pos[k] == 0) begin m_dir[k] = 0; m_pos[k] = 1; end
            else m_pos[k] = m_pos[k] - 1;
          end
        end
      end
    end
    m_pwm = rst ? 0 : (m_pwm + 1) % (1 << PWM_W);
  endtask

  initial forever begin
    @(posedge clk);
    model_clk();
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  initial forever begin
    @(negedge clk);
    if (cmp_en) begin
      chk("cyc_led1",  led1,  mled(0));
      chk("cyc_seg1",  seg1,  m_pos[0] / FR);
      chk("cyc_dir1",  dir1,  m_dir[0]);
      chk("cyc_tick1", tick1, m_tick[0]);
      chk("cyc_led4",  led4,  mled(1));
      chk("cyc_seg4",  seg4,  m_pos[1] / FR);
      chk("cyc_dir4",  dir4,  m_dir[1]);
      chk("cyc_tick4", tick4, m_tick[1]);
    end
  end

  initial begin
    int n, c0, c1, c2, c3, other, any_on, es;

    rst = 1'b1; hold = 1'b0; mode = 2'd0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    cmp_en = 1'b1;
    chk("rst_led1", led1, 0);
    chk("rst_seg1", seg1, 0);
    chk("rst_dir1", dir1, 0);
    chk("rst_tick1", tick1, 0);
    rst = 1'b0;

    // Bounce turnaround
    repeat (15) @(negedge clk);
    chk("bounce_top_seg", seg1, 3);
    chk("bounce_top_dir", dir1, 0);
    chk("bounce_tick", tick1, 1);
    @(negedge clk);
    chk("bounce_turn_seg", seg1, 3);
    chk("bounce_turn_dir", dir1, 1);
    repeat (14) @(negedge clk);
    chk("bounce_bottom_seg", seg1, 0);
    chk("bounce_bottom_dir", dir1, 1);
    @(negedge clk);
    chk("bounce_up_seg", seg1, 0);
    chk("bounce_up_dir", dir1, 0);

    // Wrap: pos 1 -> 14, hold there and measure the cross-fade
    mode = 2'd1;
    repeat (13) @(negedge clk);
    chk("wrap_pos14_seg", seg1, 3);
    hold = 1'b1;
    repeat (2) @(negedge clk);
    chk("model_br14_ch0", m_br[0][0], 2);
    chk("model_br14_ch1", m_br[0][1], 0);
    chk("model_br14_ch2", m_br[0][2], 1);
    chk("model_br14_ch3", m_br[0][3], 3);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    repeat (4) begin
      @(negedge clk);
      c0 += led1[0]; c1 += led1[1]; c2 += led1[2]; c3 += led1[3];
    end
    chk("wrap_duty_ch0", c0, 2);
    chk("wrap_duty_ch1", c1, 0);
    chk("wrap_duty_ch2", c2, 1);
    chk("wrap_duty_ch3", c3, 3);
    hold = 1'b0;
    @(negedge clk);
    chk("wrap_pos15_seg", seg1, 3);
    @(negedge clk);
    chk("wrap_pos0_seg", seg1, 0);
    chk("wrap_pos0_dir", dir1, 0);

    // PWM duty at pos 5 in bounce mode
    mode = 2'd0;
    repeat (5) @(negedge clk);
    hold = 1'b1;
    repeat (2) @(negedge clk);
    chk("model_br5_ch0", m_br[0][0], 2);
    chk("model_br5_ch1", m_br[0][1], 3);
    chk("model_br5_ch2", m_br[0][2], 1);
    chk("model_br5_ch3", m_br[0][3], 0);
    c0 = 0; c1 = 0; c2 = 0; c3 = 0;
    repeat (8) begin
      @(negedge clk);
      c0 += led1[0]; c1 += led1[1]; c2 += led1[2]; c3 += led1[3];
    end
    chk("pwm_duty_ch0", c0, 4);
    chk("pwm_duty_ch1", c1, 6);
    chk("pwm_duty_ch2", c2, 2);
    chk("pwm_duty_ch3", c3, 0);

    // Hold with the DIV=4 prescaler at its terminal count
    hold = 1'b0;
    n = 0;
    while (m_pre[1] != 3 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("hold_pre3_reached", n < 10, 1);
    hold = 1'b1;
    es = m_pos[1] / FR;
    any_on = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("hold_tick4", tick4, 0);
      chk("hold_seg4", seg4, es);
      if (i >= 4) any_on += |led1;
    end
    chk("hold_pwm_runs", any_on, 12);
    hold = 1'b0;
    @(negedge clk);
    chk("hold_release_tick4", tick4, 1);

    // Single-dot mode parked at seg 2
    mode = 2'd2;
    n = 0;
    while (m_pos[0] / FR != 2 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("single_seg2_reached", n < 40, 1);
    hold = 1'b1;
    repeat (2) @(negedge clk);
    c2 = 0; other = 0;
    repeat (8) begin
      @(negedge clk);
      c2 += led1[2];
      other += led1[0] + led1[1] + led1[3];
    end
    chk("single_duty_ch2", c2, 6);
    chk("single_others_off", other, 0);

    // Off mode: LEDs dark while the head keeps moving
    mode = 2'd3;
    hold = 1'b0;
    repeat (2) @(negedge clk);
    chk("off_led1", led1, 0);
    chk("off_led4", led4, 0);
    repeat (16) begin
      @(negedge clk);
      chk("off_led1_stay", led1, 0);
    end

    // Bounce -> wrap while descending
    mode = 2'd0;
    n = 0;
    while (m_dir[0] != 1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("desc_reached", n < 40, 1);
    chk("desc_dir1", dir1, 1);
    mode = 2'd1;
    hold = 1'b1;
    es = m_pos[0] / FR;
    @(negedge clk);
    chk("sw_wrap_dir1", dir1, 0);
    chk("sw_wrap_seg1", seg1, es);

    // Mid-run reset
    rst = 1'b1; hold = 1'b0; mode = 2'd0;
    repeat (2) @(negedge clk);
    chk("rst2_led1", led1, 0);
    chk("rst2_led4", led4, 0);
    chk("rst2_seg1", seg1, 0);
    chk("rst2_dir1", dir1, 0);
    chk("rst2_tick1", tick1, 0);
    chk("rst2_tick4", tick4, 0);
    rst = 1'b0;
    repeat (5) begin
      @(negedge clk);
      chk("rst2_tick1_run", tick1, 1);
    end

    repeat (2) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
